ansi_cmd_encoder: RTL and testbench
===================================

Name: ansi_cmd_encoder

Overview:
Transmit-side counterpart of the `commands` byte-stream decoder. It accepts one terminal command per handshake (command code plus up to two numeric arguments) and serialises the matching byte sequence, one byte per transfer. Sequences are ANSI CSI escapes (ESC [ params final), literal "clear", or literal "uname -a". Each sequence is followed by a terminator byte. It sits upstream of the decoder/UART path and is used for loopback and self-test.

Parameters:
TERM_EN, 1, 1 = append TERM_BYTE after every sequence; 0 = no terminator.
TERM_BYTE, 8'd0, terminator value; matches the decoder's inter-command separator.

Ports:
clk  input  1  clock, rising edge
_rst  input  1  synchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  encoder can accept a command; high only in IDLE
cmd_code  input  5  command code (cmd_e from package)
cmd_arg1  input  8  numeric parameter n; row for CUP/HVP
cmd_arg2  input  8  column for CUP/HVP; ignored for all other codes
out_data  output  8  byte to transmit
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts byte
cmd_err  output  1  one-cycle pulse when an undefined code is accepted

Behaviour:
- Reset (_rst low at a clk edge): state=IDLE, out_valid=0, out_data=0, cmd_err=0, latched args cleared. Inputs are ignored during reset. Reset aborts any sequence in progress immediately; no partial-sequence completion.
- cmd_ready = (state==IDLE). A command transfers when cmd_valid && cmd_ready at an edge. Code and args are latched at that edge.
- First byte presents out_valid=1 on the cycle after acceptance (1-cycle latency).
- A byte transfers when out_valid && out_ready. While out_valid && !out_ready, out_data and out_valid hold stable.
- With out_ready held high, the encoder sustains one byte per cycle.
- After the last byte (the terminator, or the final byte if TERM_EN=0) transfers, the FSM returns to IDLE. cmd_ready is high on the next cycle, so there is no back-to-back accept in the same cycle as the last byte.
- Byte mapping (decimal):
  - DELETE: 27 91 51 126.
  - CUF/CUB/CNL/CPL/CHA/ED/EL/SU/SD: 27 91 [n] F, with F = 67, 68, 69, 70, 71, 74, 75, 83, 84 respectively.
  - CUP/HVP: 27 91 [r] ; [c] F, with F = 72 / 102 and ';' = 59. If both args are 0, no params and no ';' are emitted.
  - SCP: 27 91 115. RCP: 27 91 117.
  - CLEAR: 99 108 101 97 114.
  - UNAME: 117 110 97 109 101 32 45 97.
- Parameter [n] encoding: arg 0 emits no digits. Otherwise emit 1–3 ASCII decimal digits (48+d), most significant first, with no leading zeros. Range is 0..255.
- Undefined codes (16..31): the command is accepted, cmd_err pulses for one cycle on the following cycle, no bytes are emitted, and the FSM stays in IDLE.
- FSM states: IDLE → (ESC → BRK → P1 → [SEMI → P2] → FINAL | TEXT) → TERM → IDLE.
  - P1/P2 iterate over the digit index (hundreds/tens/ones), skipping leading zeros.
  - TEXT steps a 3-bit index through the literal ROM for CLEAR/UNAME.
  - TERM is skipped when TERM_EN=0.
- Each state advances only on byte transfer.
- out_data is registered and loaded for the next state at the same edge as the transfer.

Decomposition:
- Package ansi_pkg:
  - cmd_e enum: DELETE=0, CUF=1, CUB=2, CNL=3, CPL=4, CHA=5, CUP=6, ED=7, EL=8, SU=9, SD=10, HVP=11, SCP=12, RCP=13, CLEAR=14, UNAME=15.
  - Constants ASCII_ESC=27, ASCII_LBR=91, ASCII_SEMI=59.
  - Final-byte lookup function.
  - Literal strings for CLEAR/UNAME.
  - enc_state_e FSM state enum.
- One sub-module: ansi_dec_digits. Combinational 8-bit to three BCD digits, plus a digit-count output (0..3).

Test Plan:
- DELETE with out_ready=1 → out bytes 27,91,51,126,0 on 5 consecutive cycles starting 1 cycle after accept; cmd_ready high on the cycle after the 0.
- CUF arg1=5 → 27,91,53,67,0. CHA arg1=0 → 27,91,71,0. SU arg1=100 → 27,91,49,48,48,83,0.
- CUP r=12 c=255 → 27,91,49,50,59,50,53,53,72,0. HVP r=0 c=0 → 27,91,102,0. HVP r=0 c=7 → 27,91,59,55,102,0.
- CLEAR then UNAME back-to-back with out_ready toggling 1,0,0,1 pattern → 99,108,101,97,114,0 then 117,110,97,109,101,32,45,97,0. out_data is stable during every stall; no bytes are lost or duplicated.
- Reset pulled low after the 3rd byte of CUP 12;34 → next cycle out_valid=0, cmd_ready=1. A following SCP yields 27,91,115,0.
- cmd_code=20 → cmd_err=1 for exactly one cycle, out_valid stays 0, cmd_ready stays 1. cmd_valid held high on non-IDLE cycles causes no extra acceptance.

Source files
------------

// File: rtl/ansi_pkg.sv
// Shared command codes, ASCII constants and byte lookups for the ANSI command encoder.
package ansi_pkg;

   typedef enum logic [4:0] {
      DELETE = 5'd0,  CUF = 5'd1,  CUB = 5'd2,  CNL = 5'd3,
      CPL    = 5'd4,  CHA = 5'd5,  CUP = 5'd6,  ED  = 5'd7,
      EL     = 5'd8,  SU  = 5'd9,  SD  = 5'd10, HVP = 5'd11,
      SCP    = 5'd12, RCP = 5'd13, CLEAR = 5'd14, UNAME = 5'd15
   } cmd_e;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0, S_ESC  = 4'd1, S_BRK = 4'd2, S_P1   = 4'd3,
      S_SEMI  = 4'd4, S_P2   = 4'd5, S_FINAL = 4'd6, S_TEXT = 4'd7,
      S_TERM  = 4'd8
   } enc_state_e;

   localparam logic [7:0] ASCII_ESC  = 8'd27;
   localparam logic [7:0] ASCII_LBR  = 8'd91;
   localparam logic [7:0] ASCII_SEMI = 8'd59;
   localparam logic [7:0] ASCII_ZERO = 8'd48;

   function automatic logic [7:0] final_byte(input logic [4:0] code);
      case (code)
         DELETE:  final_byte = 8'd126;
         CUF:     final_byte = 8'd67;
         CUB:     final_byte = 8'd68;
         CNL:     final_byte = 8'd69;
         CPL:     final_byte = 8'd70;
         CHA:     final_byte = 8'd71;
         CUP:     final_byte = 8'd72;
         ED:      final_byte = 8'd74;
         EL:      final_byte = 8'd75;
         SU:      final_byte = 8'd83;
         SD:      final_byte = 8'd84;
         HVP:     final_byte = 8'd102;
         SCP:     final_byte = 8'd115;
         RCP:     final_byte = 8'd117;
         default: final_byte = 8'd0;
      endcase
   endfunction

   // Literal ROM: "clear" when uname=0, "uname -a" when uname=1.
   function automatic logic [7:0] text_byte(input logic uname, input logic [2:0] idx);
      case ({uname, idx})
         4'b0_000: text_byte = 8'd99;
         4'b0_001: text_byte = 8'd108;
         4'b0_010: text_byte = 8'd101;
         4'b0_011: text_byte = 8'd97;
         4'b0_100: text_byte = 8'd114;
         4'b1_000: text_byte = 8'd117;
         4'b1_001: text_byte = 8'd110;
         4'b1_010: text_byte = 8'd97;
         4'b1_011: text_byte = 8'd109;
         4'b1_100: text_byte = 8'd101;
         4'b1_101: text_byte = 8'd32;
         4'b1_110: text_byte = 8'd45;
         4'b1_111: text_byte = 8'd97;
         default:  text_byte = 8'd0;
      endcase
   endfunction

   function automatic logic [2:0] text_last(input logic uname);
      text_last = uname ? 3'd7 : 3'd4;
   endfunction

endpackage

// File: rtl/ansi_dec_digits.sv
// Combinational binary-to-BCD conversion of one byte, with the count of significant digits.
module ansi_dec_digits (
   input  logic [7:0] value,
   output logic [3:0] hund,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic [1:0] count
);

   logic [11:0] bcd_s;

   // Double-dabble: add 3 to any nibble >= 5 before each shift.
   always_comb begin
      bcd_s = 12'd0;
      for (int i = 7; i >= 0; i--) begin
         bcd_s[3:0] = (bcd_s[3:0] >= 4'd5) ? bcd_s[3:0] + 4'd3 : bcd_s[3:0];
         bcd_s[7:4] = (bcd_s[7:4] >= 4'd5) ? bcd_s[7:4] + 4'd3 : bcd_s[7:4];
         bcd_s      = {bcd_s[10:0], value[i]};
      end
   end

   assign hund = bcd_s[11:8];
   assign tens = bcd_s[7:4];
   assign ones = bcd_s[3:0];

   // Number of digits once leading zeros are dropped.
   always_comb begin
      if (hund != 4'd0) begin
         count = 2'd3;
      end else if (tens != 4'd0) begin
         count = 2'd2;
      end else if (ones != 4'd0) begin
         count = 2'd1;
      end else begin
         count = 2'd0;
      end
   end

endmodule

// File: rtl/ansi_cmd_encoder.sv
// Serialises one terminal command per handshake into its ANSI CSI / literal byte sequence.
module ansi_cmd_encoder
   import ansi_pkg::*;
#(
   parameter bit         TERM_EN   = 1'b1,
   parameter logic [7:0] TERM_BYTE = 8'd0
) (
   input  logic       clk,
   input  logic       _rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [4:0] cmd_code,
   input  logic [7:0] cmd_arg1,
   input  logic [7:0] cmd_arg2,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       cmd_err
);

   logic [3:0] state_r;
   logic [4:0] code_r;
   logic [7:0] arg1_r, arg2_r;
   logic [1:0] idx_r;
   logic [2:0] txt_r;
   logic [7:0] out_data_r;
   logic       out_valid_r, cmd_err_r;

   logic [3:0] nxt_state_s, end_state_s;
   logic [1:0] nxt_idx_s;
   logic [2:0] nxt_txt_s;
   logic [7:0] nxt_byte_s, p1_val_s;
   logic       is_pair_s, has_p1_s, pair_sep_s, xfer_s, is_uname_s;
   logic [3:0] p1_h_s, p1_t_s, p1_o_s, p2_h_s, p2_t_s, p2_o_s;
   logic [1:0] p1_cnt_s, p2_cnt_s;

   // DELETE is emitted as a CSI with a fixed parameter of 3.
   assign p1_val_s    = (code_r == DELETE) ? 8'd3 : arg1_r;
   assign is_pair_s   = (code_r == CUP) || (code_r == HVP);
   assign has_p1_s    = (code_r != SCP) && (code_r != RCP);
   assign pair_sep_s  = is_pair_s && ((arg1_r | arg2_r) != 8'd0);
   assign is_uname_s  = (code_r == UNAME);
   assign xfer_s      = out_valid_r && out_ready;
   assign end_state_s = TERM_EN ? S_TERM : S_IDLE;

   ansi_dec_digits u_p1 (.value(p1_val_s), .hund(p1_h_s), .tens(p1_t_s), .ones(p1_o_s), .count(p1_cnt_s));
   ansi_dec_digits u_p2 (.value(arg2_r),   .hund(p2_h_s), .tens(p2_t_s), .ones(p2_o_s), .count(p2_cnt_s));

   function automatic logic [3:0] pick_digit(input logic [1:0] idx, input logic [3:0] h,
                                             input logic [3:0] t, input logic [3:0] o);
      case (idx)
         2'd0:    pick_digit = h;
         2'd1:    pick_digit = t;
         default: pick_digit = o;
      endcase
   endfunction

   // Next state and digit/text index taken when the current byte transfers.
   always_comb begin
      nxt_state_s = state_r;
      nxt_idx_s   = idx_r;
      nxt_txt_s   = txt_r;
      case (state_r)
         S_ESC:   nxt_state_s = S_BRK;
         S_BRK: begin
            if (has_p1_s && (p1_cnt_s != 2'd0)) begin
               nxt_state_s = S_P1;
               nxt_idx_s   = 2'd3 - p1_cnt_s;
            end else if (pair_sep_s) begin
               nxt_state_s = S_SEMI;
            end else begin
               nxt_state_s = S_FINAL;
            end
         end
         S_P1: begin
            if (idx_r != 2'd2) begin
               nxt_idx_s = idx_r + 2'd1;
            end else if (pair_sep_s) begin
               nxt_state_s = S_SEMI;
            end else begin
               nxt_state_s = S_FINAL;
            end
         end
         S_SEMI: begin
            if (p2_cnt_s != 2'd0) begin
               nxt_state_s = S_P2;
               nxt_idx_s   = 2'd3 - p2_cnt_s;
            end else begin
               nxt_state_s = S_FINAL;
            end
         end
         S_P2: begin
            if (idx_r != 2'd2) begin
               nxt_idx_s = idx_r + 2'd1;
            end else begin
               nxt_state_s = S_FINAL;
            end
         end
         S_FINAL: nxt_state_s = end_state_s;
         S_TEXT: begin
            if (txt_r != text_last(is_uname_s)) begin
               nxt_txt_s = txt_r + 3'd1;
            end else begin
               nxt_state_s = end_state_s;
            end
         end
         S_TERM:  nxt_state_s = S_IDLE;
         default: nxt_state_s = S_IDLE;
      endcase
   end

   // Byte presented in the state being entered.
   always_comb begin
      case (nxt_state_s)
         S_ESC:   nxt_byte_s = ASCII_ESC;
         S_BRK:   nxt_byte_s = ASCII_LBR;
         S_P1:    nxt_byte_s = ASCII_ZERO + {4'd0, pick_digit(nxt_idx_s, p1_h_s, p1_t_s, p1_o_s)};
         S_SEMI:  nxt_byte_s = ASCII_SEMI;
         S_P2:    nxt_byte_s = ASCII_ZERO + {4'd0, pick_digit(nxt_idx_s, p2_h_s, p2_t_s, p2_o_s)};
         S_FINAL: nxt_byte_s = final_byte(code_r);
         S_TEXT:  nxt_byte_s = text_byte(is_uname_s, nxt_txt_s);
         S_TERM:  nxt_byte_s = TERM_BYTE;
         default: nxt_byte_s = 8'd0;
      endcase
   end

   // Command acceptance, byte sequencing and error pulse.
   always_ff @(posedge clk) begin
      if (!_rst) begin
         state_r     <= S_IDLE;
         code_r      <= 5'd0;
         arg1_r      <= 8'd0;
         arg2_r      <= 8'd0;
         idx_r       <= 2'd0;
         txt_r       <= 3'd0;
         out_data_r  <= 8'd0;
         out_valid_r <= 1'b0;
         cmd_err_r   <= 1'b0;
      end else begin
         cmd_err_r <= 1'b0;
         if (state_r == S_IDLE) begin
            if (cmd_valid) begin
               if (cmd_code[4]) begin
                  cmd_err_r <= 1'b1;
               end else begin
                  code_r      <= cmd_code;
                  arg1_r      <= cmd_arg1;
                  arg2_r      <= cmd_arg2;
                  idx_r       <= 2'd0;
                  txt_r       <= 3'd0;
                  out_valid_r <= 1'b1;
                  if ((cmd_code == CLEAR) || (cmd_code == UNAME)) begin
                     state_r    <= S_TEXT;
                     out_data_r <= text_byte(cmd_code == UNAME, 3'd0);
                  end else begin
                     state_r    <= S_ESC;
                     out_data_r <= ASCII_ESC;
                  end
               end
            end
         end else if (xfer_s) begin
            state_r     <= nxt_state_s;
            idx_r       <= nxt_idx_s;
            txt_r       <= nxt_txt_s;
            out_data_r  <= nxt_byte_s;
            out_valid_r <= (nxt_state_s != S_IDLE);
         end
      end
   end

   assign cmd_ready = (state_r == S_IDLE);
   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
   assign cmd_err   = cmd_err_r;

endmodule

// File: tb/tb_ansi_cmd_encoder.sv
// Directed and randomized checks of ansi_cmd_encoder against a string-based byte-sequence model.
module tb_ansi_cmd_encoder;

   logic       clk = 1'b0;
   logic       _rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [4:0] cmd_code;
   logic [7:0] cmd_arg1, cmd_arg2;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       cmd_err;

   int passed = 0;
   int total  = 0;
   byte unsigned exp_q[$];

   ansi_cmd_encoder dut (
      .clk(clk), ._rst(_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_code(cmd_code), .cmd_arg1(cmd_arg1), .cmd_arg2(cmd_arg2),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic void push_str(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endfunction

   function automatic void push_num(input int n);
      if (n != 0) push_str($sformatf("%0d", n));
   endfunction

   // Reference: the expected bytes for one command, terminator included.
   function automatic void build_exp(input int code, input int a1, input int a2);
      int fin;
      exp_q.delete();
      case (code)
         14: push_str("clear");
         15: push_str("uname -a");
         default: begin
            exp_q.push_back(8'd27);
            exp_q.push_back(8'd91);
            case (code)
               0:  begin push_num(3); fin = 126; end
               1:  begin push_num(a1); fin = 67; end
               2:  begin push_num(a1); fin = 68; end
               3:  begin push_num(a1); fin = 69; end
               4:  begin push_num(a1); fin = 70; end
               5:  begin push_num(a1); fin = 71; end
               7:  begin push_num(a1); fin = 74; end
               8:  begin push_num(a1); fin = 75; end
               9:  begin push_num(a1); fin = 83; end
               10: begin push_num(a1); fin = 84; end
               12: fin = 115;
               13: fin = 117;
               default: begin
                  if (a1 != 0 || a2 != 0) begin
                     push_num(a1);
                     exp_q.push_back(8'd59);
                     push_num(a2);
                  end
                  fin = (code == 6) ? 72 : 102;
               end
            endcase
            exp_q.push_back(fin[7:0]);
         end
      endcase
      exp_q.push_back(8'd0);
   endfunction

   function automatic logic pick_ready(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
         default: return 1'(($urandom_range(0, 1)));
      endcase
   endfunction

   // Issue one command at a negedge and follow its stream; abort_at>=0 resets after that many bytes.
   task automatic send(input int code, input int a1, input int a2, input int mode, input int abort_at);
      int k = 0;
      int cyc = 0;
      logic stall = 1'b0;
      logic rdy;
      logic [7:0] held = 8'd0;
      build_exp(code, a1, a2);
      chk("idle_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_code  = code[4:0];
      cmd_arg1  = a1[7:0];
      cmd_arg2  = a2[7:0];
      @(negedge clk);
      cmd_code = 5'd20;
      chk("first_latency", out_valid, 1);
      while (k < exp_q.size() && cyc < 300) begin
         if (abort_at >= 0 && k == abort_at) begin
            cmd_valid = 1'b0;
            _rst = 1'b0;
            @(negedge clk);
            chk("abort_valid", out_valid, 0);
            chk("abort_ready", cmd_ready, 1);
            chk("abort_data", out_data, 0);
            _rst = 1'b1;
            out_ready = 1'b0;
            return;
         end
         if (stall) chk("stall_hold", out_data, held);
         chk("busy_ready", cmd_ready, 0);
         chk("busy_err", cmd_err, 0);
         rdy = pick_ready(mode, cyc);
         out_ready = rdy;
         if (out_valid && rdy) begin
            chk($sformatf("byte%0d_code%0d", k, code), out_data, exp_q[k]);
            k++;
            if (k == exp_q.size()) cmd_valid = 1'b0;
         end else if (!out_valid) begin
            chk("valid_gap", out_valid, 1);
         end
         stall = out_valid && !rdy;
         held  = out_data;
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 300) chk("stream_timeout", 0, 1);
      cmd_valid = 1'b0;
      chk("done_ready", cmd_ready, 1);
      chk("done_valid", out_valid, 0);
   endtask

   initial begin
      _rst = 1'b0; cmd_valid = 1'b0; cmd_code = 5'd0;
      cmd_arg1 = 8'd0; cmd_arg2 = 8'd0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_err", cmd_err, 0);
      _rst = 1'b1;
      @(negedge clk);

      send(0, 0, 0, 0, -1);
      send(1, 5, 0, 0, -1);
      send(5, 0, 0, 0, -1);
      send(9, 100, 0, 0, -1);
      send(6, 12, 255, 0, -1);
      send(11, 0, 0, 0, -1);
      send(11, 0, 7, 0, -1);
      send(14, 0, 0, 1, -1);
      send(15, 0, 0, 1, -1);
      send(6, 12, 34, 0, 3);
      send(12, 0, 0, 0, -1);

      cmd_valid = 1'b1; cmd_code = 5'd20;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("err_pulse", cmd_err, 1);
      chk("err_valid", out_valid, 0);
      chk("err_ready", cmd_ready, 1);
      @(negedge clk);
      chk("err_clear", cmd_err, 0);
      chk("err_valid2", out_valid, 0);

      for (int n = 0; n < 24; n++) begin
         int c, a, b;
         c = $urandom_range(0, 15);
         a = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
         b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
         send(c, a, b, $urandom_range(0, 2), -1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
